// File: rtl/conv_window_gen.sv
// 3x3 sliding-window generator: turns a raster-order N x N pixel stream into
// every fully populated 3x3 neighbourhood, with valid/ready on both sides.
module conv_window_gen #(
    parameter int N          = 100,
    parameter int DATA_WIDTH = 32,
    parameter int Q          = 10
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start_i,
    input  logic [DATA_WIDTH-1:0]   pix_i,
    input  logic                    pix_valid_i,
    output logic                    pix_ready_o,
    output logic [9*DATA_WIDTH-1:0] win_o,
    output logic                    win_valid_o,
    input  logic                    win_ready_i,
    output logic                    running_o,
    output logic                    done_o
);

    localparam int CW = $clog2(N);

    // Q only documents the pixel format; pixels pass through unmodified.
    if (Q > DATA_WIDTH) begin : g_q_exceeds_width
    end

    typedef enum logic [1:0] {StIdle, StRun, StFlush} state_e;

    state_e                state_q, state_d;
    logic [CW-1:0]         row_q, col_q;
    logic [DATA_WIDTH-1:0] lb0 [N];
    logic [DATA_WIDTH-1:0] lb1 [N];
    logic [DATA_WIDTH-1:0] win_q [9];
    logic                  win_valid_q;
    logic                  running_q;
    logic                  accept;
    logic                  last_pix;
    logic                  emit;

    assign accept   = pix_ready_o && pix_valid_i;
    assign last_pix = (row_q == CW'(N - 1)) && (col_q == CW'(N - 1));
    assign emit     = (row_q >= CW'(2)) && (col_q >= CW'(2));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (start_i) state_d = StRun;
            StRun:   if (accept && last_pix) state_d = StFlush;
            StFlush: if (win_valid_q && win_ready_i) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        pix_ready_o = (state_q == StRun) && (!win_valid_q || win_ready_i);
        // In FLUSH the only window left is the one built from the last pixel.
        done_o      = (state_q == StFlush) && win_valid_q && win_ready_i;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            row_q     <= '0;
            col_q     <= '0;
            running_q <= 1'b0;
        end else begin
            running_q <= (state_d != StIdle);
            if (state_q == StIdle && start_i) begin
                row_q <= '0;
                col_q <= '0;
            end else if (accept) begin
                if (col_q == CW'(N - 1)) begin
                    col_q <= '0;
                    row_q <= row_q + 1'b1;
                end else begin
                    col_q <= col_q + 1'b1;
                end
            end
        end
    end

    // Line buffers are not reset: a column is read only after this frame wrote it twice.
    always_ff @(posedge clk) begin
        if (accept) begin
            lb1[col_q] <= lb0[col_q];
            lb0[col_q] <= pix_i;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 9; i++) win_q[i] <= '0;
            win_valid_q <= 1'b0;
        end else begin
            if (accept) begin
                for (int r = 0; r < 3; r++) begin
                    win_q[3*r]   <= win_q[3*r+1];
                    win_q[3*r+1] <= win_q[3*r+2];
                end
                win_q[2] <= lb1[col_q];
                win_q[5] <= lb0[col_q];
                win_q[8] <= pix_i;
            end
            if (accept && emit) begin
                win_valid_q <= 1'b1;
            end else if (win_ready_i) begin
                win_valid_q <= 1'b0;
            end
        end
    end

    always_comb begin
        win_o = '0;
        for (int i = 0; i < 9; i++) win_o[DATA_WIDTH*i +: DATA_WIDTH] = win_q[i];
    end

    assign win_valid_o = win_valid_q;
    assign running_o   = running_q;

endmodule

// File: tb/tb_conv_window_gen.sv
// Directed bench for conv_window_gen: three instances (N=4, 5, 3) share stimulus,
// selected by sel; expected windows come from the raster pixel formula.
module tb_conv_window_gen;

    localparam int DW = 32;
    localparam int WW = 9 * DW;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    int            sel;
    logic          start, valid, ready;
    logic [DW-1:0] pix;

    logic          pr4, wv4, rn4, dn4, pr5, wv5, rn5, dn5, pr3, wv3, rn3, dn3;
    logic [WW-1:0] w4, w5, w3;
    logic          o_pr, o_wv, o_run, o_done;
    logic [WW-1:0] o_win;

    int            tests = 0;
    int            fails = 0;
    logic [WW-1:0] wins[$];
    logic          run_at_done;

    conv_window_gen #(.N(4), .DATA_WIDTH(DW), .Q(10)) u_dut4 (
        .clk(clk), .rst(rst), .start_i(start && sel == 4), .pix_i(pix),
        .pix_valid_i(valid && sel == 4), .pix_ready_o(pr4), .win_o(w4),
        .win_valid_o(wv4), .win_ready_i(ready), .running_o(rn4), .done_o(dn4)
    );
    conv_window_gen #(.N(5), .DATA_WIDTH(DW), .Q(10)) u_dut5 (
        .clk(clk), .rst(rst), .start_i(start && sel == 5), .pix_i(pix),
        .pix_valid_i(valid && sel == 5), .pix_ready_o(pr5), .win_o(w5),
        .win_valid_o(wv5), .win_ready_i(ready), .running_o(rn5), .done_o(dn5)
    );
    conv_window_gen #(.N(3), .DATA_WIDTH(DW), .Q(10)) u_dut3 (
        .clk(clk), .rst(rst), .start_i(start && sel == 3), .pix_i(pix),
        .pix_valid_i(valid && sel == 3), .pix_ready_o(pr3), .win_o(w3),
        .win_valid_o(wv3), .win_ready_i(ready), .running_o(rn3), .done_o(dn3)
    );

    always_comb begin
        o_pr   = (sel == 5) ? pr5 : (sel == 3) ? pr3 : pr4;
        o_wv   = (sel == 5) ? wv5 : (sel == 3) ? wv3 : wv4;
        o_run  = (sel == 5) ? rn5 : (sel == 3) ? rn3 : rn4;
        o_done = (sel == 5) ? dn5 : (sel == 3) ? dn3 : dn4;
        o_win  = (sel == 5) ? w5  : (sel == 3) ? w3  : w4;
    end

    // Window k of an n x n frame whose pixel (r,c) is base + r*n + c.
    function automatic logic [WW-1:0] exp_win(input int n, input int base, input int k);
        logic [WW-1:0] w;
        int wr, wc;
        wr = k / (n - 2);
        wc = k % (n - 2);
        w  = '0;
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
                w[DW*(3*r+c) +: DW] = DW'(base + (wr + r) * n + (wc + c));
        return w;
    endfunction

    task automatic run_frame(input int n, input int base, input int vpct, input int rpct,
                             input bit hold, input bit spurious, output int first_idx);
        int idx, held;
        bit fin;
        idx = 0; held = 0; fin = 0; first_idx = -1; run_at_done = 1'b0;
        wins.delete();
        start = 1'b1; valid = 1'b0; ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int cyc = 0; cyc < 1000 && !fin; cyc++) begin
            valid = (idx < n * n) && ($urandom_range(99) < vpct);
            pix   = DW'(base + idx);
            start = spurious && (idx == 5 || idx == n * n);
            if (hold && held < 3 && o_wv) begin
                ready = 1'b0;
                held++;
            end else begin
                ready = ($urandom_range(99) < rpct);
            end
            @(negedge clk);
            if (first_idx < 0 && o_wv) first_idx = idx;
            if (hold && !ready && o_wv) begin
                tests++;
                if (o_pr !== 1'b0) begin
                    fails++; $display("FAIL hold_pix_ready: got %0b, expected 0", o_pr);
                end
                tests++;
                if (o_win !== exp_win(n, base, 0)) begin
                    fails++; $display("FAIL hold_win: got %h, expected %h", o_win, exp_win(n, base, 0));
                end
            end
            if (o_wv && ready) wins.push_back(o_win);
            if (valid && o_pr) idx++;
            if (o_done) begin
                fin = 1;
                run_at_done = o_run;
                tests++;
                if (wins.size() != (n - 2) * (n - 2)) begin
                    fails++;
                    $display("FAIL done_at_last: got %0d windows, expected %0d", wins.size(),
                             (n - 2) * (n - 2));
                end
            end
            @(posedge clk); #1;
        end
        start = 1'b0; valid = 1'b0; ready = 1'b1;
        if (!fin) begin
            tests++; fails++;
            $display("FAIL frame_timeout: got no done_o, expected done_o (n=%0d)", n);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0; sel = 4; start = 1'b0; valid = 1'b0; ready = 1'b1; pix = '0;
        repeat (2) @(posedge clk);
        #1;
        tests++; if (o_pr !== 1'b0)  begin fails++; $display("FAIL rst_pix_ready: got %0b, expected 0", o_pr); end
        tests++; if (o_wv !== 1'b0)  begin fails++; $display("FAIL rst_win_valid: got %0b, expected 0", o_wv); end
        tests++; if (o_win !== '0)   begin fails++; $display("FAIL rst_win: got %h, expected 0", o_win); end
        tests++; if (o_run !== 1'b0) begin fails++; $display("FAIL rst_running: got %0b, expected 0", o_run); end
        tests++; if (o_done !== 1'b0) begin fails++; $display("FAIL rst_done: got %0b, expected 0", o_done); end
        rst = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_stream_n4();
        int fi, extra;
        sel = 4;
        run_frame(4, 1, 100, 100, 0, 0, fi);
        tests++; if (fi != 11) begin fails++; $display("FAIL first_valid_latency: got %0d, expected 11", fi); end
        tests++; if (wins.size() != 4) begin fails++; $display("FAIL n4_count: got %0d, expected 4", wins.size()); end
        for (int k = 0; k < 4; k++) begin
            tests++;
            if (wins[k] !== exp_win(4, 1, k)) begin
                fails++; $display("FAIL n4_win%0d: got %h, expected %h", k, wins[k], exp_win(4, 1, k));
            end
        end
        tests++; if (run_at_done !== 1'b1) begin fails++; $display("FAIL running_at_done: got %0b, expected 1", run_at_done); end
        tests++; if (o_run !== 1'b0) begin fails++; $display("FAIL running_after_done: got %0b, expected 0", o_run); end
        extra = 0;
        repeat (3) begin
            @(negedge clk);
            if (o_done) extra++;
        end
        tests++; if (extra != 0) begin fails++; $display("FAIL done_once: got %0d extra pulses, expected 0", extra); end
        @(posedge clk); #1;
    endtask

    task automatic test_backpressure();
        int fi;
        sel = 4;
        run_frame(4, 1, 100, 100, 1, 0, fi);
        tests++; if (fi != 11) begin fails++; $display("FAIL bp_first_valid: got %0d, expected 11", fi); end
        tests++; if (wins.size() != 4) begin fails++; $display("FAIL bp_count: got %0d, expected 4", wins.size()); end
        for (int k = 0; k < 4; k++) begin
            tests++;
            if (wins[k] !== exp_win(4, 1, k)) begin
                fails++; $display("FAIL bp_win%0d: got %h, expected %h", k, wins[k], exp_win(4, 1, k));
            end
        end
    endtask

    task automatic test_bubbles_n5();
        int fi;
        sel = 5;
        run_frame(5, 1, 50, 50, 0, 0, fi);
        tests++; if (wins.size() != 9) begin fails++; $display("FAIL n5_count: got %0d, expected 9", wins.size()); end
        for (int k = 0; k < 9; k++) begin
            tests++;
            if (wins[k] !== exp_win(5, 1, k)) begin
                fails++; $display("FAIL n5_win%0d: got %h, expected %h", k, wins[k], exp_win(5, 1, k));
            end
        end
    endtask

    task automatic test_reset_midframe();
        int idx, fi;
        sel = 4; idx = 0;
        start = 1'b1; @(posedge clk); #1; start = 1'b0;
        for (int cyc = 0; cyc < 50 && idx < 7; cyc++) begin
            valid = 1'b1; pix = DW'(1 + idx);
            @(negedge clk);
            if (o_pr) idx++;
            @(posedge clk); #1;
        end
        valid = 1'b0;
        tests++; if (o_run !== 1'b1) begin fails++; $display("FAIL pre_reset_running: got %0b, expected 1", o_run); end
        rst = 1'b0;
        #1;
        tests++; if (o_pr !== 1'b0)  begin fails++; $display("FAIL async_pix_ready: got %0b, expected 0", o_pr); end
        tests++; if (o_run !== 1'b0) begin fails++; $display("FAIL async_running: got %0b, expected 0", o_run); end
        tests++; if (o_win !== '0)   begin fails++; $display("FAIL async_win: got %h, expected 0", o_win); end
        tests++; if (o_wv !== 1'b0)  begin fails++; $display("FAIL async_win_valid: got %0b, expected 0", o_wv); end
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        run_frame(4, 101, 100, 70, 0, 0, fi);
        tests++; if (wins.size() != 4) begin fails++; $display("FAIL rr_count: got %0d, expected 4", wins.size()); end
        for (int k = 0; k < 4; k++) begin
            tests++;
            if (wins[k] !== exp_win(4, 101, k)) begin
                fails++; $display("FAIL rr_win%0d: got %h, expected %h", k, wins[k], exp_win(4, 101, k));
            end
        end
    endtask

    task automatic test_back_to_back();
        int fi;
        sel = 4;
        run_frame(4, 1, 100, 60, 0, 1, fi);
        for (int k = 0; k < 4; k++) begin
            tests++;
            if (wins[k] !== exp_win(4, 1, k)) begin
                fails++; $display("FAIL spurious_win%0d: got %h, expected %h", k, wins[k], exp_win(4, 1, k));
            end
        end
        run_frame(4, 201, 100, 100, 0, 0, fi);
        tests++; if (wins.size() != 4) begin fails++; $display("FAIL b2b_count: got %0d, expected 4", wins.size()); end
        for (int k = 0; k < 4; k++) begin
            tests++;
            if (wins[k] !== exp_win(4, 201, k)) begin
                fails++; $display("FAIL b2b_win%0d: got %h, expected %h", k, wins[k], exp_win(4, 201, k));
            end
        end
    endtask

    task automatic test_n3();
        int fi;
        sel = 3;
        run_frame(3, 1, 100, 100, 0, 0, fi);
        tests++; if (fi != 9) begin fails++; $display("FAIL n3_first_valid: got %0d, expected 9", fi); end
        tests++; if (wins.size() != 1) begin fails++; $display("FAIL n3_count: got %0d, expected 1", wins.size()); end
        tests++;
        if (wins[0] !== exp_win(3, 1, 0)) begin
            fails++; $display("FAIL n3_win: got %h, expected %h", wins[0], exp_win(3, 1, 0));
        end
    endtask

    initial begin
        test_reset();
        test_stream_n4();
        test_backpressure();
        test_bubbles_n5();
        test_reset_midframe();
        test_back_to_back();
        test_n3();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
